// File: rtl/lynx_flit_pkg.sv
// Shared flit definitions for the lynx NoC: field bit positions and scheduler state encoding.
package lynx_flit_pkg;

  typedef enum logic {IDLE, LOCKED} sched_state_t;

  function automatic int unsigned valid_bit(input int unsigned w);
    return w - 1;
  endfunction

  function automatic int unsigned head_bit(input int unsigned w);
    return w - 2;
  endfunction

  function automatic int unsigned tail_bit(input int unsigned w);
    return w - 3;
  endfunction

  // Lowest bit of the VC id field; dest sits directly below it.
  function automatic int unsigned vc_lsb(input int unsigned w, input int unsigned vcw);
    return w - 3 - vcw;
  endfunction

  function automatic int unsigned dest_lsb(input int unsigned w, input int unsigned vcw,
                                           input int unsigned aw);
    return w - 3 - vcw - aw;
  endfunction

endpackage

// File: rtl/depacketizer_vc_sched_if.sv
// Flit bus between router VC buffers, the VC scheduler and the depacketizer input.
interface depacketizer_vc_sched_if #(
  parameter int unsigned WIDTH_PKT = 36,
  parameter int unsigned NUM_VC    = 2
);
  logic [NUM_VC*WIDTH_PKT-1:0] vc_data_in;
  logic [NUM_VC-1:0]           vc_ready_out;
  logic [WIDTH_PKT-1:0]        pkt_out;
  logic                        pkt_ready_in;

  modport master (
    input  vc_data_in,
    input  pkt_ready_in,
    output vc_ready_out,
    output pkt_out
  );

  modport slave (
    output vc_data_in,
    output pkt_ready_in,
    input  vc_ready_out,
    input  pkt_out
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo NUM_VC.
module rr_arbiter #(
  parameter int unsigned NUM_VC = 2
) (
  input  logic [NUM_VC-1:0]         req,
  input  logic [$clog2(NUM_VC)-1:0] ptr,
  output logic [NUM_VC-1:0]         grant,
  output logic [$clog2(NUM_VC)-1:0] idx,
  output logic                      any_grant
);
  localparam int unsigned IDX_W = $clog2(NUM_VC);

  int unsigned pos;

  always_comb begin
    any_grant = 1'b0;
    idx       = '0;
    pos       = 0;
    for (int unsigned k = 0; k < NUM_VC; k++) begin
      pos = (32'(ptr) + k) % NUM_VC;
      if (!any_grant && req[IDX_W'(pos)]) begin
        any_grant = 1'b1;
        idx       = IDX_W'(pos);
      end
    end
    grant = any_grant ? (NUM_VC'(1) << idx) : '0;
  end

endmodule

// File: rtl/depacketizer_vc_sched.sv
// Packet-atomic round-robin scheduler sharing one depacketizer between NUM_VC router VCs.
// A VC is granted on a head flit and keeps the lock until its tail flit transfers.
module depacketizer_vc_sched
  import lynx_flit_pkg::*;
#(
  parameter int unsigned WIDTH_PKT        = 36,
  parameter int unsigned VC_ADDRESS_WIDTH = 1,
  parameter int unsigned ADDRESS_WIDTH    = 4,
  parameter int unsigned NUM_VC           = 2,
  parameter int unsigned CNT_WIDTH        = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  depacketizer_vc_sched_if.master     bus,
  output logic [$clog2(NUM_VC)-1:0]   grant_vc,
  output logic                        busy,
  output logic [CNT_WIDTH-1:0]        pkt_count,
  output logic                        proto_err
);
  localparam int unsigned IDX_W = $clog2(NUM_VC);
  localparam int unsigned VB    = valid_bit(WIDTH_PKT);
  localparam int unsigned HB    = head_bit(WIDTH_PKT);
  localparam int unsigned TB    = tail_bit(WIDTH_PKT);

  if (NUM_VC < 2 || NUM_VC > 8) begin : g_bad_num_vc
    $error("depacketizer_vc_sched: NUM_VC must be in 2..8");
  end
  if (WIDTH_PKT < 3 + VC_ADDRESS_WIDTH + ADDRESS_WIDTH) begin : g_bad_width
    $error("depacketizer_vc_sched: WIDTH_PKT too small for header fields");
  end

  sched_state_t           state_q, state_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   first_q, first_d;
  logic [WIDTH_PKT-1:0]   pkt_q, pkt_d;

  logic [WIDTH_PKT-1:0]   vc_flit [NUM_VC];
  logic [NUM_VC-1:0]      head_req;
  logic [NUM_VC-1:0]      bad_req;
  logic [NUM_VC-1:0]      vc_ready_c;
  logic [WIDTH_PKT-1:0]   sel_flit;
  logic                   adv;
  logic                   xfer;

  logic [NUM_VC-1:0]      arb_grant;
  logic [IDX_W-1:0]       arb_idx;
  logic                   arb_any;
  logic                   unused_arb_grant;

  // Per-VC flit slices and eligibility: heads may be granted, orphan bodies are errors.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign vc_flit[i]  = bus.vc_data_in[i*WIDTH_PKT +: WIDTH_PKT];
    assign head_req[i] = vc_flit[i][VB] &  vc_flit[i][HB];
    assign bad_req[i]  = vc_flit[i][VB] & ~vc_flit[i][HB];
  end

  rr_arbiter #(.NUM_VC(NUM_VC)) u_arb (
    .req       (head_req),
    .ptr       (rr_ptr_q),
    .grant     (arb_grant),
    .idx       (arb_idx),
    .any_grant (arb_any)
  );

  assign unused_arb_grant = ^arb_grant;

  assign adv      = ~pkt_q[VB] | bus.pkt_ready_in;
  assign sel_flit = vc_flit[grant_q];

  // Next-state, transfer and output-stage logic.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    first_d    = first_q;
    pkt_d      = pkt_q;
    vc_ready_c = '0;
    xfer       = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bad_req) err_d = 1'b1;
        if (arb_any) begin
          grant_d = arb_idx;
          first_d = 1'b1;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        vc_ready_c[grant_q] = adv;
        xfer = adv & sel_flit[VB];
        if (xfer) begin
          first_d = 1'b0;
          if (sel_flit[HB] && !first_q) err_d = 1'b1;
          if (sel_flit[TB]) begin
            state_d  = IDLE;
            rr_ptr_d = (grant_q == IDX_W'(NUM_VC - 1)) ? '0 : grant_q + IDX_W'(1);
            cnt_d    = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Output register advances whenever it is empty or being drained.
    if (adv) pkt_d = xfer ? sel_flit : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
      pkt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      first_q  <= first_d;
      pkt_q    <= pkt_d;
    end
  end

  assign bus.vc_ready_out = vc_ready_c;
  assign bus.pkt_out      = pkt_q;
  assign grant_vc         = grant_q;
  assign busy             = (state_q == LOCKED);
  assign pkt_count        = cnt_q;
  assign proto_err        = err_q;

endmodule

// File: tb/tb_depacketizer_vc_sched.sv
// Directed self-checking bench for depacketizer_vc_sched (2 VCs, 4-bit packet counter).
module tb_depacketizer_vc_sched;
  localparam int unsigned W   = 36;
  localparam int unsigned NVC = 2;
  localparam int unsigned CW  = 4;

  logic clk;
  logic rst_n;
  logic [0:0]    grant_vc;
  logic          busy;
  logic [CW-1:0] pkt_count;
  logic          proto_err;

  depacketizer_vc_sched_if #(.WIDTH_PKT(W), .NUM_VC(NVC)) bus ();

  depacketizer_vc_sched #(
    .WIDTH_PKT(W), .VC_ADDRESS_WIDTH(1), .ADDRESS_WIDTH(4), .NUM_VC(NVC), .CNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .grant_vc  (grant_vc),
    .busy      (busy),
    .pkt_count (pkt_count),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] q0 [$];
  logic [W-1:0] q1 [$];
  logic [W-1:0] got [$];
  logic [W-1:0] exp_q [$];
  int           tail_vc [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk(input logic h, input logic t, input logic vc,
                                      input logic [3:0] dest, input logic [27:0] pl);
    return {1'b1, h, t, vc, dest, pl};
  endfunction

  task automatic drive();
    logic [W-1:0] f0, f1;
    f0 = (q0.size() != 0) ? q0[0] : '0;
    f1 = (q1.size() != 0) ? q1[0] : '0;
    bus.vc_data_in = {f1, f0};
  endtask

  // One clock: sample handshakes before the edge, then update VC queues after it.
  task automatic cycle();
    logic [W-1:0] f0, f1;
    logic a0, a1;
    @(negedge clk);
    f0 = bus.vc_data_in[W-1:0];
    f1 = bus.vc_data_in[2*W-1:W];
    a0 = bus.vc_ready_out[0] & f0[W-1];
    a1 = bus.vc_ready_out[1] & f1[W-1];
    if (bus.pkt_out[W-1] && bus.pkt_ready_in) got.push_back(bus.pkt_out);
    if (a0 && f0[W-3]) tail_vc.push_back(0);
    if (a1 && f1[W-3]) tail_vc.push_back(1);
    @(posedge clk);
    #1;
    if (a0) void'(q0.pop_front());
    if (a1) void'(q1.pop_front());
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete(); q1.delete(); got.delete(); exp_q.delete(); tail_vc.delete();
    bus.pkt_ready_in = 1'b1;
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_idle(input int max_cyc, input string tag);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      done = (q0.size() == 0) && (q1.size() == 0) && !busy && !bus.pkt_out[W-1];
      if (!done) begin
        cycle();
        n++;
      end
    end
    check({tag, " drained"}, 64'(done), 64'd1);
  endtask

  task automatic compare_got(input string tag);
    check({tag, " flit count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s flit%0d", tag, i), (i < got.size()) ? 64'(got[i]) : 64'd0,
            64'(exp_q[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] h, b, b2, t;
    rst_n = 1'b0;
    bus.vc_data_in = '0;
    bus.pkt_ready_in = 1'b1;

    // Reset values and a single 3-flit packet with exact latency.
    do_reset();
    check("rst pkt_out", 64'(bus.pkt_out), 64'd0);
    check("rst vc_ready", 64'(bus.vc_ready_out), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst grant_vc", 64'(grant_vc), 64'd0);
    check("rst pkt_count", 64'(pkt_count), 64'd0);
    check("rst proto_err", 64'(proto_err), 64'd0);
    h = mk(1'b1, 1'b0, 1'b0, 4'h3, 28'h0000111);
    b = mk(1'b0, 1'b0, 1'b0, 4'h3, 28'h0000222);
    t = mk(1'b0, 1'b1, 1'b0, 4'h3, 28'h0000333);
    q0.push_back(h); q0.push_back(b); q0.push_back(t);
    drive();
    cycle();
    check("t1 busy after arb", 64'(busy), 64'd1);
    check("t1 pkt_out empty after arb", 64'(bus.pkt_out), 64'd0);
    cycle();
    check("t1 head on pkt_out", 64'(bus.pkt_out), 64'(h));
    cycle();
    check("t1 body on pkt_out", 64'(bus.pkt_out), 64'(b));
    check("t1 busy mid packet", 64'(busy), 64'd1);
    cycle();
    check("t1 tail on pkt_out", 64'(bus.pkt_out), 64'(t));
    check("t1 busy after tail", 64'(busy), 64'd0);
    check("t1 pkt_count", 64'(pkt_count), 64'd1);
    cycle();
    check("t1 pkt_out cleared", 64'(bus.pkt_out), 64'd0);

    // Two VCs start together: VC0 whole packet, then VC1.
    do_reset();
    q0.push_back(mk(1'b1, 1'b0, 1'b0, 4'h1, 28'hA0));
    q0.push_back(mk(1'b0, 1'b1, 1'b0, 4'h1, 28'hA1));
    q1.push_back(mk(1'b1, 1'b0, 1'b1, 4'h2, 28'hB0));
    q1.push_back(mk(1'b0, 1'b1, 1'b1, 4'h2, 28'hB1));
    exp_q = {q0[0], q0[1], q1[0], q1[1]};
    drive();
    cycle();
    check("t2 first grant", 64'(grant_vc), 64'd0);
    run_until_idle(50, "t2");
    compare_got("t2");
    check("t2 tail0 vc", 64'((tail_vc.size() > 0) ? tail_vc[0] : 9), 64'd0);
    check("t2 tail1 vc", 64'((tail_vc.size() > 1) ? tail_vc[1] : 9), 64'd1);

    // Back-to-back contention, four 2-flit packets per VC, then counter wrap.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      q0.push_back(mk(1'b1, 1'b0, 1'b0, 4'h5, 28'(16 * p + 0)));
      q0.push_back(mk(1'b0, 1'b1, 1'b0, 4'h5, 28'(16 * p + 1)));
      q1.push_back(mk(1'b1, 1'b0, 1'b1, 4'h6, 28'(16 * p + 8)));
      q1.push_back(mk(1'b0, 1'b1, 1'b1, 4'h6, 28'(16 * p + 9)));
    end
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(q0[2*p]); exp_q.push_back(q0[2*p+1]);
      exp_q.push_back(q1[2*p]); exp_q.push_back(q1[2*p+1]);
    end
    drive();
    run_until_idle(200, "t3");
    compare_got("t3");
    for (int i = 0; i < 8; i++)
      check($sformatf("t3 tail order %0d", i), 64'((i < tail_vc.size()) ? tail_vc[i] : 9),
            64'(i % 2));
    check("t3 pkt_count", 64'(pkt_count), 64'd8);
    for (int p = 0; p < 4; p++) begin
      q0.push_back(mk(1'b1, 1'b1, 1'b0, 4'h7, 28'(p)));
      q1.push_back(mk(1'b1, 1'b1, 1'b1, 4'h7, 28'(p)));
    end
    drive();
    run_until_idle(200, "t3 wrap");
    check("t3 pkt_count wrap", 64'(pkt_count), 64'd0);

    // Backpressure for 5 cycles mid-packet.
    do_reset();
    q0.push_back(mk(1'b1, 1'b0, 1'b0, 4'h9, 28'h40));
    q0.push_back(mk(1'b0, 1'b0, 1'b0, 4'h9, 28'h41));
    q0.push_back(mk(1'b0, 1'b0, 1'b0, 4'h9, 28'h42));
    q0.push_back(mk(1'b0, 1'b1, 1'b0, 4'h9, 28'h43));
    exp_q = {q0[0], q0[1], q0[2], q0[3]};
    drive();
    cycle();
    cycle();
    check("t4 head out", 64'(bus.pkt_out), 64'(exp_q[0]));
    bus.pkt_ready_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("t4 stall%0d pkt_out", k), 64'(bus.pkt_out), 64'(exp_q[0]));
      check($sformatf("t4 stall%0d vc_ready", k), 64'(bus.vc_ready_out), 64'd0);
    end
    check("t4 nothing consumed", 64'(q0.size()), 64'd3);
    bus.pkt_ready_in = 1'b1;
    #1;
    check("t4 ready resumes", 64'(bus.vc_ready_out), 64'd1);
    cycle();
    check("t4 body after resume", 64'(bus.pkt_out), 64'(exp_q[1]));
    run_until_idle(50, "t4");
    compare_got("t4");

    // Orphan body flit while idle.
    do_reset();
    q1.push_back(mk(1'b0, 1'b0, 1'b1, 4'h2, 28'h55));
    drive();
    cycle();
    check("t5 idle body err", 64'(proto_err), 64'd1);
    check("t5 idle body no lock", 64'(busy), 64'd0);
    cycle();
    check("t5 body not consumed", 64'(q1.size()), 64'd1);
    check("t5 vc_ready idle", 64'(bus.vc_ready_out), 64'd0);
    // Head flit inside a locked packet.
    do_reset();
    check("t5 err cleared by reset", 64'(proto_err), 64'd0);
    q0.push_back(mk(1'b1, 1'b0, 1'b0, 4'h4, 28'h60));
    q0.push_back(mk(1'b1, 1'b0, 1'b0, 4'h4, 28'h61));
    q0.push_back(mk(1'b0, 1'b1, 1'b0, 4'h4, 28'h62));
    exp_q = {q0[0], q0[1], q0[2]};
    drive();
    cycle();
    cycle();
    check("t5 first head no err", 64'(proto_err), 64'd0);
    cycle();
    check("t5 mid head err", 64'(proto_err), 64'd1);
    run_until_idle(50, "t5");
    compare_got("t5");
    check("t5 pkt_count", 64'(pkt_count), 64'd1);

    // Async reset mid-packet with rr_ptr advanced to 1.
    do_reset();
    q0.push_back(mk(1'b1, 1'b1, 1'b0, 4'h1, 28'h70));
    drive();
    cycle();
    cycle();
    check("t6 single-flit count", 64'(pkt_count), 64'd1);
    h  = mk(1'b1, 1'b0, 1'b0, 4'h1, 28'h71);
    b  = mk(1'b0, 1'b0, 1'b0, 4'h1, 28'h72);
    b2 = mk(1'b0, 1'b0, 1'b0, 4'h1, 28'h73);
    t  = mk(1'b0, 1'b1, 1'b0, 4'h1, 28'h74);
    q0.push_back(h); q0.push_back(b); q0.push_back(b2); q0.push_back(t);
    drive();
    cycle();
    cycle();
    cycle();
    check("t6 busy before reset", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async pkt_out", 64'(bus.pkt_out), 64'd0);
    check("t6 async busy", 64'(busy), 64'd0);
    check("t6 async grant_vc", 64'(grant_vc), 64'd0);
    check("t6 async pkt_count", 64'(pkt_count), 64'd0);
    check("t6 async vc_ready", 64'(bus.vc_ready_out), 64'd0);
    q0.delete(); q1.delete(); got.delete(); tail_vc.delete();
    q0.push_back(mk(1'b1, 1'b0, 1'b0, 4'h3, 28'h80));
    q0.push_back(mk(1'b0, 1'b1, 1'b0, 4'h3, 28'h81));
    q1.push_back(mk(1'b1, 1'b0, 1'b1, 4'h3, 28'h90));
    q1.push_back(mk(1'b0, 1'b1, 1'b1, 4'h3, 28'h91));
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    check("t6 grant from rr_ptr 0", 64'(grant_vc), 64'd0);
    check("t6 busy after rearb", 64'(busy), 64'd1);
    run_until_idle(50, "t6");
    check("t6 tail0 vc", 64'((tail_vc.size() > 0) ? tail_vc[0] : 9), 64'd0);
    check("t6 tail1 vc", 64'((tail_vc.size() > 1) ? tail_vc[1] : 9), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
